// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner states, special key codes and the row/column to key-code map
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  // nibble at index {row,col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  localparam logic [63:0] KEY_LUT = {4'hD, KEY_HASH, 4'h0, KEY_STAR, 16'hC987, 16'hB654, 16'hA321};
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [3:0] keymap(input logic [3:0] row, input logic [3:0] col);
    return KEY_LUT[{onehot_idx(row), onehot_idx(col), 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: W-bit two-flop synchronizer; ports clk, rst (async, high), d (async in), q (synced out)
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan/debounce; in clk, reset (async high), fila[3:0]; out col[3:0], key_valid, key_code[3:0], key_held
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  logic [3:0] fila_s;
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic [3:0] pat_q, pat_d, col_q, col_d, key_code_q, key_code_d, col_rot;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d;
  sync2 #(.W(4)) u_sync (.clk(clk), .rst(reset), .d(fila), .q(fila_s));
  assign col_rot = {col_q[2:0], col_q[3]};
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    pat_d       = pat_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      SCAN:
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (fila_s != 4'd0) begin
            pat_d   = fila_s;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else
            col_d = col_rot;
        end else
          div_d = div_q + DW'(1);
      DEBOUNCE:
        if (fila_s != pat_q) begin
          state_d = SCAN;
          col_d   = col_rot;
          div_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          rel_d   = '0;
          // chords across rows are accepted as a hold but never reported
          if ($onehot(pat_q)) begin
            key_valid_d = 1'b1;
            key_code_d  = keymap(pat_q, col_q);
          end
        end else
          cnt_d = cnt_q + CW'(1);
      HELD:
        if (fila_s != 4'd0)
          rel_d = '0;
        else if (rel_q == CNT_LAST) begin
          state_d = SCAN;
          col_d   = col_rot;
          div_d   = '0;
        end else
          rel_d = rel_q + CW'(1);
      default: state_d = SCAN;
    endcase
    key_held_d = state_d == HELD;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= SCAN;
      div_q       <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      pat_q       <= '0;
      col_q       <= 4'b0001;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      pat_q       <= pat_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a modelled key matrix
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] fila, col, key_code;
  logic key_valid, key_held;
  logic [3:0] press_row, press_col;
  logic [3:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYC(3)) dut (
    .clk(clk), .reset(reset), .fila(fila), .col(col),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
  );
  always #10 clk = ~clk;
  assign fila = |(col & press_col) ? press_row : 4'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_held(input logic v);
    for (int i = 0; i < 200 && key_held !== v; i++) @(negedge clk);
    chk("wait_held", key_held, v);
  endtask
  task automatic wait_col(input logic [3:0] c);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (col === c) break;
    end
    chk("wait_col", col, c);
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask
  always @(negedge clk)
    if (!reset && key_valid) begin
      chk("held_at_valid", key_held, 1);
      if (exp_q.size() == 0) chk("spurious_valid", key_valid, 0);
      else chk("key_code", key_code, exp_q.pop_front());
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    press_row = '0;
    press_col = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_col", col, 4'b0001);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("scan_col", col, 32'(1) << ((k / 4) % 4));
    end
    press_row = 4'b0010; press_col = 4'b0010;
    exp_q.push_back(4'h5);
    wait_held(1);
    repeat (5) begin @(negedge clk); chk("held_hold", key_held, 1); end
    press_row = '0;
    for (int k = 1; k <= 4; k++) begin @(negedge clk); chk("held_release", key_held, 1); end
    @(negedge clk);
    chk("held_drop", key_held, 0);
    chk("resume_col", col, 4'b0100);
    chk("pending_5", exp_q.size(), 0);
    wait_col(4'b0001);
    @(negedge clk);
    press_row = 4'b0001; press_col = 4'b0001;
    repeat (2) @(negedge clk);
    press_row = '0;
    repeat (2) @(negedge clk);
    chk("bounce_col_hold", col, 4'b0001);
    @(negedge clk);
    chk("bounce_col_abort", col, 4'b0010);
    chk("bounce_held", key_held, 0);
    press_row = 4'b1000; press_col = 4'b0100;
    exp_q.push_back(4'hF);
    wait_held(1);
    repeat (100) @(negedge clk);
    chk("long_held", key_held, 1);
    press_row = '0;
    wait_held(0);
    chk("pending_f1", exp_q.size(), 0);
    press_row = 4'b1000;
    exp_q.push_back(4'hF);
    wait_held(1);
    repeat (10) @(negedge clk);
    press_row = '0;
    wait_held(0);
    chk("pending_f2", exp_q.size(), 0);
    press_row = 4'b0011; press_col = 4'b0001;
    wait_held(1);
    repeat (10) @(negedge clk);
    chk("chord_held", key_held, 1);
    press_row = '0;
    wait_held(0);
    chk("chord_pending", exp_q.size(), 0);
    wait_col(4'b0100);
    press_row = 4'b0100; press_col = 4'b0010;
    wait_col(4'b0010);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_col", col, 4'b0001);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_held", key_held, 0);
    repeat (2) begin @(negedge clk); chk("in_rst_valid", key_valid, 0); end
    reset = 1'b0;
    exp_q.push_back(4'h8);
    wait_drain();
    chk("after_rst_held", key_held, 1);
    press_row = '0;
    wait_held(0);
    repeat (20) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
